// File: rtl/eth_decap_core_if.sv
// MAC RX stream and TLP FIFO write port of the NetTLP RX decapsulator.
// The slave modport is the core's view; master is the surrounding MAC/FIFO view.
interface eth_decap_core_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tuser;
    logic        wr_en;
    logic        full;
    logic [63:0] din_tdata;
    logic [7:0]  din_tkeep;
    logic        din_tlast;
    logic        din_err;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, full,
        output s_tready, wr_en, din_tdata, din_tkeep, din_tlast, din_err
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, full,
        input  s_tready, wr_en, din_tdata, din_tkeep, din_tlast, din_err
    );
endinterface

// File: rtl/eth_decap_core.sv
// NetTLP RX decapsulator: parses the 48-byte Eth/IPv4/UDP/NetTLP header, filters,
// and streams the remaining TLP qwords into the PCIe-side FIFO.
module eth_decap_core #(
    parameter logic [15:0] UDP_PORT_MR  = 16'h3000,
    parameter logic [15:0] UDP_PORT_CPL = 16'h4000
) (
    input  logic                   eth_clk,
    input  logic                   eth_rst,
    eth_decap_core_if.slave        bus,
    input  logic [47:0]            adapter_reg_srcmac,
    input  logic [31:0]            adapter_reg_srcip,
    output logic [31:0]            rx_pkt_cnt,
    output logic [31:0]            rx_drop_cnt,
    output logic [15:0]            rx_seq_err_cnt
);
    localparam int unsigned HDR_BEATS = 6;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned PORT_W    = 17;

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match_q, match_d;
    logic [15:0]        exp_seq_q, exp_seq_d;
    logic               pkt_inc, drop_inc, seq_err_inc;
    logic               beat_ok;
    logic [63:0]        d;
    logic [47:0]        dst_mac;
    logic [15:0]        dport, seq;
    logic               mr_hit, cpl_hit;

    // Multi-byte header fields are big-endian on the wire; lane n carries wire byte n of the beat.
    assign d       = bus.s_tdata;
    assign dst_mac = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    assign dport   = {d[39:32], d[47:40]};
    assign seq     = {d[23:16], d[31:24]};
    assign mr_hit  = (PORT_W'(dport) >= PORT_W'(UDP_PORT_MR)) &&
                     (PORT_W'(dport) <= PORT_W'(UDP_PORT_MR) + PORT_W'(15));
    assign cpl_hit = (PORT_W'(dport) >= PORT_W'(UDP_PORT_CPL)) &&
                     (PORT_W'(dport) <= PORT_W'(UDP_PORT_CPL) + PORT_W'(255));

    // Per-beat header check, selected by qword position within the header.
    always_comb begin
        beat_ok = 1'b1;
        case (count_q)
            3'd0:    beat_ok = (dst_mac == adapter_reg_srcmac) || (dst_mac == 48'hFFFF_FFFF_FFFF);
            3'd1:    beat_ok = (d[39:32] == 8'h08) && (d[47:40] == 8'h00) && (d[55:48] == 8'h45);
            3'd2:    beat_ok = (d[63:56] == 8'd17);
            3'd3:    beat_ok = ({d[55:48], d[63:56]} == adapter_reg_srcip[31:16]);
            3'd4:    beat_ok = ({d[7:0], d[15:8]} == adapter_reg_srcip[15:0]) && (mr_hit || cpl_hit);
            default: beat_ok = 1'b1;
        endcase
    end

    // Next-state, handshake and counter-increment decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        match_d      = match_q;
        exp_seq_d    = exp_seq_q;
        pkt_inc      = 1'b0;
        drop_inc     = 1'b0;
        seq_err_inc  = 1'b0;
        bus.s_tready = 1'b1;
        bus.wr_en    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (bus.s_tvalid) begin
                    match_d = (count_q == '0) ? beat_ok : (match_q & beat_ok);
                    if (bus.s_tlast) begin
                        drop_inc = 1'b1;
                        count_d  = '0;
                    end else if (count_q == CNT_W'(HDR_BEATS - 1)) begin
                        count_d = '0;
                        if (match_d) begin
                            state_d     = ST_PAYLOAD;
                            pkt_inc     = 1'b1;
                            seq_err_inc = (seq != exp_seq_q);
                            exp_seq_d   = seq + 16'd1;
                        end else begin
                            state_d  = ST_DROP;
                            drop_inc = 1'b1;
                        end
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                bus.s_tready = !bus.full;
                bus.wr_en    = bus.s_tvalid & !bus.full;
                if (bus.s_tvalid && !bus.full && bus.s_tlast) begin
                    state_d = ST_HDR;
                    count_d = '0;
                end
            end
            ST_DROP: begin
                if (bus.s_tvalid && bus.s_tlast) begin
                    state_d = ST_HDR;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_HDR;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state_q        <= ST_HDR;
            count_q        <= '0;
            match_q        <= 1'b0;
            exp_seq_q      <= '0;
            rx_pkt_cnt     <= '0;
            rx_drop_cnt    <= '0;
            rx_seq_err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            match_q   <= match_d;
            exp_seq_q <= exp_seq_d;
            if (pkt_inc)     rx_pkt_cnt     <= rx_pkt_cnt + 32'd1;
            if (drop_inc)    rx_drop_cnt    <= rx_drop_cnt + 32'd1;
            if (seq_err_inc) rx_seq_err_cnt <= rx_seq_err_cnt + 16'd1;
        end
    end

    // TLP side: each 32-bit dword is byte-reversed to undo the TX encapsulator.
    assign bus.din_tdata = {d[39:32], d[47:40], d[55:48], d[63:56],
                            d[7:0],   d[15:8],  d[23:16], d[31:24]};
    assign bus.din_tkeep = bus.s_tkeep;
    assign bus.din_tlast = bus.s_tlast;
    assign bus.din_err   = bus.s_tuser & bus.s_tlast;

endmodule

// File: tb/tb_eth_decap_core.sv
// Self-checking bench for eth_decap_core: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_eth_decap_core;
    localparam logic [15:0] PORT_MR  = 16'h3000;
    localparam logic [15:0] PORT_CPL = 16'h4000;
    localparam logic [47:0] OWN_MAC  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] OWN_IP   = 32'hC0A8_0A02;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    logic        eth_clk = 1'b0;
    logic        eth_rst = 1'b1;
    logic [31:0] rx_pkt_cnt, rx_drop_cnt;
    logic [15:0] rx_seq_err_cnt;

    always #5 eth_clk = ~eth_clk;

    eth_decap_core_if bus();

    eth_decap_core #(.UDP_PORT_MR(PORT_MR), .UDP_PORT_CPL(PORT_CPL)) dut (
        .eth_clk            (eth_clk),
        .eth_rst            (eth_rst),
        .bus                (bus),
        .adapter_reg_srcmac (OWN_MAC),
        .adapter_reg_srcip  (OWN_IP),
        .rx_pkt_cnt         (rx_pkt_cnt),
        .rx_drop_cnt        (rx_drop_cnt),
        .rx_seq_err_cnt     (rx_seq_err_cnt)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference model state
    logic [31:0] m_pkt, m_drop;
    logic [15:0] m_seqerr, m_expseq;
    logic [63:0] fr_q[$];
    logic [7:0]  fr_last_keep;
    logic        fr_user;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int first, input int n);
        logic [63:0] q;
        q = fr_q[first + n / 8];
        return q[8 * (n % 8) +: 8];
    endfunction

    function automatic logic [63:0] swap_dw(input logic [63:0] x);
        int lmap [0:7] = '{3, 2, 1, 0, 7, 6, 5, 4};
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8 * i +: 8] = x[8 * lmap[i] +: 8];
        return r;
    endfunction

    // 1 when the frame starting at beat 'first' should be forwarded
    function automatic int classify(input int first);
        logic [47:0] dst;
        logic [31:0] ip;
        logic [15:0] et, dp;
        int          p;
        if (fr_q.size() - first <= 6) return 0;
        dst = {fb(first, 0), fb(first, 1), fb(first, 2), fb(first, 3), fb(first, 4), fb(first, 5)};
        ip  = {fb(first, 30), fb(first, 31), fb(first, 32), fb(first, 33)};
        et  = {fb(first, 12), fb(first, 13)};
        dp  = {fb(first, 36), fb(first, 37)};
        p   = int'(dp);
        if (dst != OWN_MAC && dst != BCAST) return 0;
        if (et != 16'h0800 || fb(first, 14) != 8'h45 || fb(first, 23) != 8'd17) return 0;
        if (ip != OWN_IP) return 0;
        if (p >= int'(PORT_MR) && p <= int'(PORT_MR) + 15) return 1;
        if (p >= int'(PORT_CPL) && p <= int'(PORT_CPL) + 255) return 1;
        return 0;
    endfunction

    task automatic make_frame(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] etype,
                              input logic [7:0] ver, input logic [7:0] proto, input logic [15:0] dport,
                              input logic [15:0] seq, input int nbeats, input logic [7:0] keep,
                              input logic user);
        logic [7:0]  b [0:47];
        logic [63:0] q;
        for (int i = 0; i < 48; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) b[i] = mac[8 * (5 - i) +: 8];
        b[12] = etype[15:8]; b[13] = etype[7:0]; b[14] = ver; b[23] = proto;
        for (int i = 0; i < 4; i++) b[30 + i] = ip[8 * (3 - i) +: 8];
        b[36] = dport[15:8]; b[37] = dport[7:0];
        b[42] = seq[15:8];   b[43] = seq[7:0];
        fr_q = {};
        for (int k = 0; k < nbeats; k++) begin
            if (k < 6) for (int n = 0; n < 8; n++) q[8 * n +: 8] = b[8 * k + n];
            else       q = {$urandom, $urandom};
            fr_q.push_back(q);
        end
        fr_last_keep = keep;
        fr_user      = user;
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".pkt"},  64'(rx_pkt_cnt),     64'(m_pkt));
        check({tag, ".drop"}, 64'(rx_drop_cnt),    64'(m_drop));
        check({tag, ".seq"},  64'(rx_seq_err_cnt), 64'(m_seqerr));
    endtask

    // Drive beats first.. of fr_q; abort_at >= 0 pulses reset before that beat.
    task automatic send(input int first, input int abort_at, input int gaps, input int full_mode);
        int          fwd, i, n, waitc, burst_start, cyc;
        logic        in_pay, rdy_exp, wr_exp, last;
        logic [15:0] seq;
        n = fr_q.size();
        fwd = classify(first);
        i = first; cyc = 0; waitc = 0; burst_start = -1;
        while (i < n) begin
            if (i == abort_at) begin
                bus.s_tvalid = 1'b0; bus.full = 1'b0; eth_rst = 1'b1;
                @(posedge eth_clk); #1;
                eth_rst = 1'b0;
                m_pkt = '0; m_drop = '0; m_seqerr = '0; m_expseq = '0;
                @(negedge eth_clk);
                check_counters("rst_mid");
                check("rst_mid.wr_en",    64'(bus.wr_en),    64'(0));
                check("rst_mid.s_tready", 64'(bus.s_tready), 64'(1));
                @(posedge eth_clk); #1;
                return;
            end
            last         = (i == n - 1);
            bus.s_tvalid = (gaps != 0 && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
            bus.s_tdata  = fr_q[i];
            bus.s_tkeep  = last ? fr_last_keep : 8'hFF;
            bus.s_tlast  = last;
            bus.s_tuser  = last ? fr_user : 1'b0;
            if (full_mode == 1) bus.full = 1'($urandom_range(1));
            else if (full_mode == 2) begin
                if (burst_start < 0 && fwd != 0 && i - first == 7) burst_start = cyc;
                bus.full = (burst_start >= 0 && cyc < burst_start + 4);
            end else bus.full = 1'b0;
            @(negedge eth_clk);
            in_pay  = (fwd != 0) && (i - first >= 6);
            rdy_exp = in_pay ? !bus.full : 1'b1;
            wr_exp  = in_pay && bus.s_tvalid && !bus.full;
            check("s_tready", 64'(bus.s_tready), 64'(rdy_exp));
            check("wr_en",    64'(bus.wr_en),    64'(wr_exp));
            if (wr_exp) begin
                check("din_tdata", bus.din_tdata,       swap_dw(fr_q[i]));
                check("din_tkeep", 64'(bus.din_tkeep),  64'(bus.s_tkeep));
                check("din_tlast", 64'(bus.din_tlast),  64'(last));
                check("din_err",   64'(bus.din_err),    64'(last && fr_user));
            end
            @(posedge eth_clk); #1;
            cyc++;
            if (bus.s_tvalid && rdy_exp) begin
                i++; waitc = 0;
            end else if (++waitc > 200) begin
                check("beat_timeout", 64'(waitc), 64'(0));
                break;
            end
        end
        bus.s_tvalid = 1'b0; bus.full = 1'b0; bus.s_tlast = 1'b0; bus.s_tuser = 1'b0;
        if (fwd != 0) begin
            m_pkt++;
            seq = {fb(first, 42), fb(first, 43)};
            if (seq != m_expseq) m_seqerr++;
            m_expseq = seq + 16'd1;
        end else m_drop++;
        @(negedge eth_clk);
        check_counters("frame");
        @(posedge eth_clk); #1;
    endtask

    task automatic good(input logic [47:0] mac, input logic [15:0] dport, input logic [15:0] seq,
                        input int nbeats);
        make_frame(mac, OWN_IP, 16'h0800, 8'h45, 8'd17, dport, seq, nbeats, 8'hFF, 1'b0);
    endtask

    initial begin
        int          kind, nb, gaps, fm;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] et, dp, sq;
        logic [7:0]  ver, pr;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tkeep = '0;
        bus.s_tlast = 1'b0;  bus.s_tuser = 1'b0; bus.full = 1'b0;
        m_pkt = '0; m_drop = '0; m_seqerr = '0; m_expseq = '0;

        repeat (3) @(posedge eth_clk);
        #1 eth_rst = 1'b0;
        @(negedge eth_clk);
        check_counters("reset");
        check("reset.s_tready", 64'(bus.s_tready), 64'(1));
        check("reset.wr_en",    64'(bus.wr_en),    64'(0));
        @(posedge eth_clk); #1;

        // MemWr, 3 payload qwords
        good(OWN_MAC, 16'(PORT_MR + 16'd3), 16'd0, 9);
        send(0, -1, 0, 0);
        // IP daddr mismatch
        make_frame(OWN_MAC, OWN_IP ^ 32'h1, 16'h0800, 8'h45, 8'd17, 16'(PORT_MR + 16'd3), 16'd1, 9, 8'hFF, 1'b0);
        send(0, -1, 0, 0);
        // Completion with a 4-cycle FIFO-full burst mid-payload
        good(OWN_MAC, 16'(PORT_CPL + 16'd200), 16'd1, 14);
        send(0, -1, 0, 2);
        // Runt then valid frame
        good(OWN_MAC, PORT_MR, 16'd2, 4);
        send(0, -1, 0, 0);
        good(OWN_MAC, PORT_MR, 16'd2, 8);
        send(0, -1, 1, 1);
        // Seq 3,4,6 -> one error; broadcast destination
        good(BCAST, 16'(PORT_MR + 16'd15), 16'd3, 7);
        send(0, -1, 0, 0);
        good(OWN_MAC, 16'(PORT_CPL + 16'd255), 16'd4, 7);
        send(0, -1, 0, 0);
        good(OWN_MAC, PORT_CPL, 16'd6, 8);
        send(0, -1, 1, 0);
        // Empty TLP (header only) and bad frame flag on payload
        good(OWN_MAC, PORT_MR, 16'd7, 6);
        send(0, -1, 0, 0);
        make_frame(OWN_MAC, OWN_IP, 16'h0800, 8'h45, 8'd17, PORT_MR, 16'd7, 9, 8'h0F, 1'b1);
        send(0, -1, 0, 0);
        // Reset mid-payload; leftovers parse as a new header; then a clean frame
        good(OWN_MAC, 16'(PORT_MR + 16'd1), 16'd9, 16);
        send(0, 8, 0, 0);
        send(8, -1, 0, 0);
        good(OWN_MAC, 16'(PORT_MR + 16'd1), 16'd0, 10);
        send(0, -1, 1, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 11);
            mac = OWN_MAC; ip = OWN_IP; et = 16'h0800; ver = 8'h45; pr = 8'd17;
            dp  = 16'(PORT_MR + 16'($urandom_range(0, 15)));
            sq  = ($urandom_range(3) == 0) ? 16'($urandom) : m_expseq;
            nb  = $urandom_range(7, 12);
            case (kind)
                1:  dp  = 16'(PORT_CPL + 16'($urandom_range(0, 255)));
                2:  mac = OWN_MAC ^ (48'h1 << $urandom_range(0, 47));
                3:  ip  = OWN_IP ^ (32'h1 << $urandom_range(0, 31));
                4:  et  = 16'h86DD;
                5:  ver = 8'h46;
                6:  pr  = 8'd6;
                7:  dp  = 16'(PORT_MR + 16'd16);
                8:  dp  = 16'(PORT_MR - 16'd1);
                9:  dp  = 16'(PORT_CPL + 16'd256);
                10: nb  = $urandom_range(1, 6);
                11: mac = BCAST;
                default: ;
            endcase
            gaps = $urandom_range(1);
            fm   = $urandom_range(1);
            make_frame(mac, ip, et, ver, pr, dp, sq, nb, 8'hFF >> $urandom_range(0, 7),
                       ($urandom_range(7) == 0));
            send(0, -1, gaps, fm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
